lc3b_mem_arbiter: RTL and testbench
===================================

Name: lc3b_mem_arbiter

Overview:
- Shares one physical memory port between the pipeline's instruction-fetch side (mem1) and data side (mem2).
- Sits between the pipelined datapath (or its L1 caches) and physical memory.
- Arbitrates with a round-robin, last-grant policy. Holds the granted request on the physical port until pmem_resp, then routes the response back to the owner only.
- Has a watchdog that flags a memory transaction that never completes.

Parameters:
ADDR_WIDTH, 16, address width (lc3b_word)
DATA_WIDTH, 16, data width (lc3b_word)
TIMEOUT, 255, max cycles a granted transaction may wait for pmem_resp before err_timeout; 0 disables the watchdog

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous, active-low reset
mem1_read  in  1  instruction read request, held until mem1_resp
mem1_address  in  ADDR_WIDTH  instruction address
mem1_rdata  out  DATA_WIDTH  instruction read data
mem1_resp  out  1  one-cycle completion pulse to fetch side
mem2_read  in  1  data read request, held until mem2_resp
mem2_write  in  1  data write request, held until mem2_resp
mem2_wmask  in  2  byte write mask (lc3b_mem_wmask)
mem2_address  in  ADDR_WIDTH  data address
mem2_wdata  in  DATA_WIDTH  data write value
mem2_rdata  out  DATA_WIDTH  data read data
mem2_resp  out  1  one-cycle completion pulse to data side
pmem_read  out  1  physical read strobe
pmem_write  out  1  physical write strobe
pmem_wmask  out  2  physical byte mask
pmem_address  out  ADDR_WIDTH  physical address
pmem_wdata  out  DATA_WIDTH  physical write data
pmem_rdata  in  DATA_WIDTH  physical read data
pmem_resp  in  1  physical completion, one cycle
err_timeout  out  1  sticky watchdog flag

Behaviour:
- Asynchronous reset (reset_n=0) forces:
  - state=IDLE, last_grant=MEM1 (so mem2 wins the first tie), wd_cnt=0.
  - pmem_read, pmem_write, pmem_wmask, pmem_address, pmem_wdata all 0.
  - mem1_resp, mem2_resp, err_timeout all 0.
- Reset mid-transaction abandons it. No resp is issued and the requester must reissue.
- FSM has three states: IDLE, GRANT1, GRANT2.
- IDLE:
  - Requests are sampled: req1=mem1_read, req2=mem2_read|mem2_write.
  - Only req1 -> GRANT1. Only req2 -> GRANT2.
  - Both -> the side not equal to last_grant.
  - Neither -> stay in IDLE.
- Latency: a request first high in IDLE cycle N has the pmem strobes asserted from cycle N+1 (strobes are registered from state). Minimum request-to-resp latency is 2 cycles.
- GRANT1:
  - pmem_read=1, pmem_write=0, pmem_address=mem1_address (combinational passthrough while granted).
  - mem1_rdata=pmem_rdata. mem1_resp=pmem_resp.
- GRANT2:
  - pmem_read=mem2_read&~mem2_write, pmem_write=mem2_write.
  - pmem_address, pmem_wmask, pmem_wdata pass through from mem2.
  - mem2_rdata=pmem_rdata. mem2_resp=pmem_resp.
  - mem2_read and mem2_write both high is treated as a write.
- Completion: on a pmem_resp cycle in GRANTx:
  - next state=IDLE and last_grant=x.
  - The strobes drop in the following cycle (a one-cycle IDLE bubble guarantees pmem sees a deasserted strobe between transactions).
  - A request still high in that IDLE cycle is a new request.
- The non-granted side:
  - Its resp is 0 and its rdata is 0.
  - Its request is ignored and must stay held.
- pmem_resp in IDLE is ignored and produces no mem*_resp.
- Requester drops its request while granted (protocol violation): the arbiter keeps the grant until pmem_resp and still pulses resp.
- Watchdog:
  - wd_cnt clears on entering GRANTx and increments each GRANTx cycle without pmem_resp.
  - When wd_cnt reaches TIMEOUT, err_timeout is set. It is sticky until reset and does not change the FSM.
  - wd_cnt saturates at TIMEOUT and is 8 bits wide.
- Fairness: with both sides continuously requesting, grants strictly alternate. Neither side waits more than one other transaction plus one bubble.

Test Plan:
- Reset, then mem1_read=1 with mem1_address=16'h0060, and pmem responds 3 cycles after pmem_read rises with rdata=16'h1234 -> pmem_read rises the cycle after the request; mem1_rdata=16'h1234 with a one-cycle mem1_resp; pmem_read=0 the next cycle.
- mem2_write=1, mem2_wmask=2'b01, mem2_address=16'h0102, mem2_wdata=16'hABCD -> pmem_write=1 with exact passthrough of mask, address and data; pmem_read=0; mem1_resp stays 0 throughout.
- mem1_read and mem2_read both asserted in the first cycle after reset -> mem2 granted first; after its resp and one bubble, mem1 is granted; with both held, grants alternate 2,1,2,1 over 4 transactions.
- Stray pmem_resp pulse while IDLE -> no mem1_resp or mem2_resp, state stays IDLE; mem2_read and mem2_write both high -> pmem_write=1, pmem_read=0.
- TIMEOUT=4 and pmem_resp withheld after a mem1 grant -> err_timeout rises after 4 granted cycles and stays high; a later pmem_resp still completes mem1; err_timeout is cleared only by reset_n.
- reset_n pulsed low during GRANT2 -> all outputs go to 0 immediately (asynchronously); after release, a pending mem1 and mem2 tie is granted to mem2.

Source files
------------

// File: rtl/lc3b_mem_arbiter.sv
// Round-robin arbiter sharing one physical memory port between
// the fetch side (mem1) and the data side (mem2), with a watchdog.
module lc3b_mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  mem1_read,
  input  logic [ADDR_WIDTH-1:0] mem1_address,
  output logic [DATA_WIDTH-1:0] mem1_rdata,
  output logic                  mem1_resp,
  input  logic                  mem2_read,
  input  logic                  mem2_write,
  input  logic [1:0]            mem2_wmask,
  input  logic [ADDR_WIDTH-1:0] mem2_address,
  input  logic [DATA_WIDTH-1:0] mem2_wdata,
  output logic [DATA_WIDTH-1:0] mem2_rdata,
  output logic                  mem2_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [1:0]            pmem_wmask,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [DATA_WIDTH-1:0] pmem_wdata,
  input  logic [DATA_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp,
  output logic                  err_timeout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT1 = 2'd1,
    GRANT2 = 2'd2
  } state_t;

  localparam logic LG_MEM1 = 1'b0;
  localparam logic LG_MEM2 = 1'b1;
  localparam logic [7:0] WD_MAX = 8'(TIMEOUT);
  localparam logic WD_EN = (TIMEOUT != 0);

  state_t     state, state_n;
  logic       last_grant, last_grant_n;
  logic [7:0] wd_cnt, wd_cnt_n;
  logic       req1, req2;
  logic       granted;

  assign req1    = mem1_read;
  assign req2    = mem2_read | mem2_write;
  assign granted = (state == GRANT1) || (state == GRANT2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      last_grant  <= LG_MEM1;
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
      wd_cnt     <= wd_cnt_n;
      if (WD_EN && granted && !pmem_resp && wd_cnt_n == WD_MAX)
        err_timeout <= 1'b1;
    end
  end

  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    unique case (state)
      IDLE: begin
        if (req1 && req2)
          state_n = (last_grant == LG_MEM1) ? GRANT2 : GRANT1;
        else if (req1)
          state_n = GRANT1;
        else if (req2)
          state_n = GRANT2;
      end
      GRANT1: begin
        if (pmem_resp) begin
          state_n      = IDLE;
          last_grant_n = LG_MEM1;
        end
      end
      GRANT2: begin
        if (pmem_resp) begin
          state_n      = IDLE;
          last_grant_n = LG_MEM2;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Counter restarts on every fresh grant and saturates at the limit.
  always_comb begin
    wd_cnt_n = wd_cnt;
    if (state == IDLE && state_n != IDLE)
      wd_cnt_n = '0;
    else if (granted && !pmem_resp && wd_cnt != WD_MAX)
      wd_cnt_n = wd_cnt + 8'd1;
  end

  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_wmask   = '0;
    pmem_address = '0;
    pmem_wdata   = '0;
    mem1_rdata   = '0;
    mem1_resp    = 1'b0;
    mem2_rdata   = '0;
    mem2_resp    = 1'b0;
    unique case (state)
      GRANT1: begin
        pmem_read    = 1'b1;
        pmem_address = mem1_address;
        mem1_rdata   = pmem_rdata;
        mem1_resp    = pmem_resp;
      end
      GRANT2: begin
        pmem_read    = mem2_read & ~mem2_write;
        pmem_write   = mem2_write;
        pmem_wmask   = mem2_wmask;
        pmem_address = mem2_address;
        pmem_wdata   = mem2_wdata;
        mem2_rdata   = pmem_rdata;
        mem2_resp    = pmem_resp;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// Directed bench for lc3b_mem_arbiter: grant order, passthrough,
// stray responses, watchdog and asynchronous reset.
module tb_lc3b_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem1_read;
  logic [15:0] mem1_address;
  logic [15:0] mem1_rdata;
  logic        mem1_resp;
  logic        mem2_read;
  logic        mem2_write;
  logic [1:0]  mem2_wmask;
  logic [15:0] mem2_address;
  logic [15:0] mem2_wdata;
  logic [15:0] mem2_rdata;
  logic        mem2_resp;
  logic        pmem_read;
  logic        pmem_write;
  logic [1:0]  pmem_wmask;
  logic [15:0] pmem_address;
  logic [15:0] pmem_wdata;
  logic [15:0] pmem_rdata;
  logic        pmem_resp;
  logic        err_timeout;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lc3b_mem_arbiter #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(16),
    .TIMEOUT(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .mem1_read(mem1_read),
    .mem1_address(mem1_address),
    .mem1_rdata(mem1_rdata),
    .mem1_resp(mem1_resp),
    .mem2_read(mem2_read),
    .mem2_write(mem2_write),
    .mem2_wmask(mem2_wmask),
    .mem2_address(mem2_address),
    .mem2_wdata(mem2_wdata),
    .mem2_rdata(mem2_rdata),
    .mem2_resp(mem2_resp),
    .pmem_read(pmem_read),
    .pmem_write(pmem_write),
    .pmem_wmask(pmem_wmask),
    .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp),
    .err_timeout(err_timeout)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    mem1_read  = 1'b0;
    mem2_read  = 1'b0;
    mem2_write = 1'b0;
  endtask

  logic [15:0] exp_addr [4];
  logic        exp_two  [4];

  initial begin
    reset_n      = 1'b0;
    mem1_read    = 1'b0;
    mem1_address = '0;
    mem2_read    = 1'b0;
    mem2_write   = 1'b0;
    mem2_wmask   = '0;
    mem2_address = '0;
    mem2_wdata   = '0;
    pmem_rdata   = '0;
    pmem_resp    = 1'b0;
    #1;
    chk("rst_pmem_read", pmem_read, 1'b0);
    chk("rst_pmem_write", pmem_write, 1'b0);
    chk("rst_pmem_address", pmem_address, 16'h0);
    chk("rst_err", err_timeout, 1'b0);
    chk("rst_resp", {mem1_resp, mem2_resp}, 2'b00);
    tick();
    reset_n = 1'b1;
    tick();

    // mem1 read, pmem answers 3 cycles after the strobe rises
    mem1_read    = 1'b1;
    mem1_address = 16'h0060;
    #1;
    chk("t1_idle_no_strobe", pmem_read, 1'b0);
    tick();
    chk("t1_pmem_read", pmem_read, 1'b1);
    chk("t1_pmem_address", pmem_address, 16'h0060);
    chk("t1_pmem_write", pmem_write, 1'b0);
    tick();
    tick();
    tick();
    pmem_resp  = 1'b1;
    pmem_rdata = 16'h1234;
    #1;
    chk("t1_mem1_resp", mem1_resp, 1'b1);
    chk("t1_mem1_rdata", mem1_rdata, 16'h1234);
    chk("t1_mem2_resp", mem2_resp, 1'b0);
    tick();
    pmem_resp = 1'b0;
    clear_reqs();
    #1;
    chk("t1_bubble_read", pmem_read, 1'b0);
    chk("t1_bubble_resp", mem1_resp, 1'b0);
    chk("t1_bubble_rdata", mem1_rdata, 16'h0);

    // mem2 write passthrough
    mem2_write   = 1'b1;
    mem2_wmask   = 2'b01;
    mem2_address = 16'h0102;
    mem2_wdata   = 16'hABCD;
    pmem_rdata   = 16'h5555;
    tick();
    chk("t2_pmem_write", pmem_write, 1'b1);
    chk("t2_pmem_read", pmem_read, 1'b0);
    chk("t2_pmem_wmask", pmem_wmask, 2'b01);
    chk("t2_pmem_address", pmem_address, 16'h0102);
    chk("t2_pmem_wdata", pmem_wdata, 16'hABCD);
    chk("t2_mem1_rdata", mem1_rdata, 16'h0);
    tick();
    chk("t2_mem1_resp_wait", mem1_resp, 1'b0);
    pmem_resp = 1'b1;
    #1;
    chk("t2_mem2_resp", mem2_resp, 1'b1);
    chk("t2_mem1_resp", mem1_resp, 1'b0);
    tick();
    pmem_resp = 1'b0;
    clear_reqs();
    #1;
    chk("t2_bubble_write", pmem_write, 1'b0);

    // tie straight after reset, then strict alternation
    reset_n = 1'b0;
    tick();
    reset_n      = 1'b1;
    mem1_read    = 1'b1;
    mem1_address = 16'h0100;
    mem2_read    = 1'b1;
    mem2_address = 16'h0200;
    exp_addr[0] = 16'h0200; exp_two[0] = 1'b1;
    exp_addr[1] = 16'h0100; exp_two[1] = 1'b0;
    exp_addr[2] = 16'h0200; exp_two[2] = 1'b1;
    exp_addr[3] = 16'h0100; exp_two[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t3_addr_%0d", i), pmem_address, exp_addr[i]);
      chk($sformatf("t3_read_%0d", i), pmem_read, 1'b1);
      pmem_resp  = 1'b1;
      pmem_rdata = 16'h7000 + 16'(i);
      #1;
      chk($sformatf("t3_resp_%0d", i), {mem1_resp, mem2_resp},
          exp_two[i] ? 2'b01 : 2'b10);
      tick();
      pmem_resp = 1'b0;
      if (i == 3) clear_reqs();
      #1;
      chk($sformatf("t3_bubble_%0d", i), pmem_read, 1'b0);
    end
    tick();
    chk("t3_idle_after", {pmem_read, pmem_write}, 2'b00);

    // stray pmem_resp while idle, then read+write collision
    pmem_resp = 1'b1;
    #1;
    chk("t4_stray_resp", {mem1_resp, mem2_resp}, 2'b00);
    tick();
    pmem_resp = 1'b0;
    #1;
    chk("t4_still_idle", {pmem_read, pmem_write}, 2'b00);
    mem2_read    = 1'b1;
    mem2_write   = 1'b1;
    mem2_address = 16'h0300;
    tick();
    chk("t4_rw_write", pmem_write, 1'b1);
    chk("t4_rw_read", pmem_read, 1'b0);
    pmem_resp = 1'b1;
    #1;
    chk("t4_rw_resp", mem2_resp, 1'b1);
    tick();
    pmem_resp = 1'b0;
    clear_reqs();

    // watchdog with TIMEOUT=4
    mem1_read    = 1'b1;
    mem1_address = 16'h0400;
    tick();
    chk("t5_grant1", pmem_read, 1'b1);
    chk("t5_err_g1", err_timeout, 1'b0);
    tick();
    tick();
    tick();
    chk("t5_err_g4", err_timeout, 1'b0);
    tick();
    chk("t5_err_set", err_timeout, 1'b1);
    tick();
    tick();
    chk("t5_err_sticky", err_timeout, 1'b1);
    chk("t5_still_granted", pmem_read, 1'b1);
    pmem_resp  = 1'b1;
    pmem_rdata = 16'hBEEF;
    #1;
    chk("t5_late_resp", mem1_resp, 1'b1);
    chk("t5_late_rdata", mem1_rdata, 16'hBEEF);
    tick();
    pmem_resp = 1'b0;
    clear_reqs();
    tick();
    chk("t5_err_after", err_timeout, 1'b1);

    // asynchronous reset during GRANT2
    mem2_read    = 1'b1;
    mem2_address = 16'h0500;
    tick();
    chk("t6_grant2", pmem_read, 1'b1);
    chk("t6_addr", pmem_address, 16'h0500);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_async_read", pmem_read, 1'b0);
    chk("t6_async_addr", pmem_address, 16'h0);
    chk("t6_async_err", err_timeout, 1'b0);
    mem1_read    = 1'b1;
    mem1_address = 16'h0600;
    tick();
    reset_n = 1'b1;
    tick();
    chk("t6_tie_mem2", pmem_address, 16'h0500);
    pmem_resp = 1'b1;
    #1;
    chk("t6_resp", {mem1_resp, mem2_resp}, 2'b01);
    tick();
    pmem_resp = 1'b0;
    clear_reqs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
